// File: rtl/branch_pkg.sv
// Shared definitions for the fetch-side branch/PC logic: control-transfer
// codes, the reset PC default and the sequential fetch increment.
package branch_pkg;

  // D-stage control-transfer code; values 11-15 are unused and behave as BrNone.
  typedef enum logic [3:0] {
    BrNone = 4'd0,
    BrBeq  = 4'd1,
    BrBne  = 4'd2,
    BrBlez = 4'd3,
    BrBgtz = 4'd4,
    BrBltz = 4'd5,
    BrBgez = 4'd6,
    BrJ    = 4'd7,
    BrJal  = 4'd8,
    BrJr   = 4'd9,
    BrJalr = 4'd10
  } br_type_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Conditional branches BEQ..BGEZ (the ones that consult the compare flags).
  function automatic logic is_cond_branch(input logic [3:0] bt);
    return (bt >= 4'(BrBeq)) && (bt <= 4'(BrBgez));
  endfunction

  // Register-indirect jumps, whose target comes straight from rs.
  function automatic logic is_reg_jump(input logic [3:0] bt);
    return (bt == 4'(BrJr)) || (bt == 4'(BrJalr));
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Purely combinational resolution of a D-stage control transfer: decides
// whether it is taken and which address fetch should be redirected to.
// Also produces the link address (pc_d + 8, past the delay slot).
module branch_target_gen
  import branch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic [3:0]          br_type,
  input  logic                zero,
  input  logic                gez,
  input  logic                gz,
  input  logic                lez,
  input  logic                lz,
  input  logic [PC_WIDTH-1:0] pc_d,
  input  logic [15:0]         imm16,
  input  logic [25:0]         idx26,
  input  logic [PC_WIDTH-1:0] rs_val,
  output logic                taken,
  output logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] link_pc
);

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] j_target;

  // Candidate targets, all in wrap-around arithmetic.
  always_comb begin
    pc_plus4  = pc_d + PC_WIDTH'(PC_INC);
    br_target = pc_plus4 + {{(PC_WIDTH - 18){imm16[15]}}, imm16, 2'b00};
    // Jumps stay inside the 256 MB region of the delay-slot instruction.
    j_target  = {pc_plus4[PC_WIDTH-1:28], idx26, 2'b00};
    link_pc   = pc_d + PC_WIDTH'(2 * PC_INC);
  end

  // Taken decision and target mux per control-transfer code.
  always_comb begin
    taken  = 1'b0;
    target = pc_plus4;
    unique case (br_type)
      BrBeq:  begin taken = zero;  target = br_target; end
      BrBne:  begin taken = !zero; target = br_target; end
      BrBlez: begin taken = lez;   target = br_target; end
      BrBgtz: begin taken = gz;    target = br_target; end
      BrBltz: begin taken = lz;    target = br_target; end
      BrBgez: begin taken = gez;   target = br_target; end
      BrJ,
      BrJal:  begin taken = 1'b1;  target = j_target;  end
      BrJr,
      BrJalr: begin taken = 1'b1;  target = rs_val;    end
      default: begin taken = 1'b0; target = pc_plus4;  end
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch-stage PC owner. Resolves the D-stage control transfer via
// branch_target_gen and redirects fetch one cycle later (the instruction
// already in F is the delay slot). Flags misaligned jr/jalr targets.
// Optional BRANCH_STATS_EN adds br_count/taken_count for conditional branches.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [3:0]          br_type,
  input  logic                zero,
  input  logic                gez,
  input  logic                gz,
  input  logic                lez,
  input  logic                lz,
  input  logic [PC_WIDTH-1:0] pc_d,
  input  logic [15:0]         imm16,
  input  logic [25:0]         idx26,
  input  logic [PC_WIDTH-1:0] rs_val,
  output logic [PC_WIDTH-1:0] pc_f,
  output logic                taken,
  output logic [PC_WIDTH-1:0] link_pc,
  output logic                jr_misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         br_count,
  output logic [31:0]         taken_count
`endif
);

  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_f_q, pc_f_d;
  logic                jr_misalign_q, jr_misalign_d;

  branch_target_gen #(
    .PC_WIDTH (PC_WIDTH)
  ) u_target_gen (
    .br_type (br_type),
    .zero    (zero),
    .gez     (gez),
    .gz      (gz),
    .lez     (lez),
    .lz      (lz),
    .pc_d    (pc_d),
    .imm16   (imm16),
    .idx26   (idx26),
    .rs_val  (rs_val),
    .taken   (taken),
    .target  (target),
    .link_pc (link_pc)
  );

  // Next PC and misalign flag; a stall freezes both, and a stalled taken
  // transfer simply re-resolves next cycle because D holds too.
  always_comb begin
    pc_f_d        = pc_f_q;
    jr_misalign_d = jr_misalign_q;
    if (!stall) begin
      pc_f_d        = taken ? target : (pc_f_q + PC_WIDTH'(PC_INC));
      // The misaligned target is still loaded; the flag lets the core trap.
      jr_misalign_d = taken && is_reg_jump(br_type) && (rs_val[1:0] != 2'b00);
    end
  end

  // PC and misalign state, async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q        <= RESET_PC;
      jr_misalign_q <= 1'b0;
    end else begin
      pc_f_q        <= pc_f_d;
      jr_misalign_q <= jr_misalign_d;
    end
  end

  assign pc_f        = pc_f_q;
  assign jr_misalign = jr_misalign_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] taken_count_q, taken_count_d;

  // Only conditional branches are counted; jumps are always taken and uninteresting.
  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (!stall && is_cond_branch(br_type)) begin
      br_count_d = br_count_q + 32'd1;
      if (taken) begin
        taken_count_d = taken_count_q + 32'd1;
      end
    end
  end

  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count_q    <= 32'd0;
      taken_count_q <= 32'd0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vectors, a behavioural
// next-PC model compared every cycle, plus hand-computed literal checks.
// Define BRANCH_STATS_EN to also exercise the statistics counters.
module tb_branch_pc_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  br_type = 4'd0;
  logic        zero = 1'b0, gez = 1'b0, gz = 1'b0, lez = 1'b0, lz = 1'b0;
  logic [31:0] pc_d = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] idx26 = 26'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] pc_f;
  logic        taken;
  logic [31:0] link_pc;
  logic        jr_misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, taken_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_brc, m_tkc;

  branch_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_type     (br_type),
    .zero        (zero),
    .gez         (gez),
    .gz          (gz),
    .lez         (lez),
    .lz          (lz),
    .pc_d        (pc_d),
    .imm16       (imm16),
    .idx26       (idx26),
    .rs_val      (rs_val),
    .pc_f        (pc_f),
    .taken       (taken),
    .link_pc     (link_pc),
    .jr_misalign (jr_misalign)
`ifdef BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  always #5 clk = ~clk;

  // Taken rule straight from the code table (numeric codes).
  function automatic logic f_taken(input logic [3:0] bt, input logic [4:0] fl);
    // fl = {zero, gez, gz, lez, lz}
    case (int'(bt))
      1: return fl[4];
      2: return !fl[4];
      3: return fl[1];
      4: return fl[2];
      5: return fl[0];
      6: return fl[3];
      7, 8, 9, 10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_target(input logic [3:0] bt, input logic [31:0] pcd,
                                           input logic [15:0] im, input logic [25:0] ix,
                                           input logic [31:0] rs);
    int code = int'(bt);
    if (code >= 1 && code <= 6) return pcd + 32'd4 + 32'(int'($signed(im)) * 4);
    if (code == 7 || code == 8) return ((pcd + 32'd4) & 32'hF000_0000) + 32'(ix) * 32'd4;
    return rs;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: next PC from the spec's selection rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc  <= 32'h0000_3000;
      m_mis <= 1'b0;
      m_brc <= 32'd0;
      m_tkc <= 32'd0;
    end else if (!stall) begin
      if (f_taken(br_type, {zero, gez, gz, lez, lz})) begin
        m_pc  <= f_target(br_type, pc_d, imm16, idx26, rs_val);
        m_mis <= (br_type == 4'd9 || br_type == 4'd10) && (rs_val % 4 != 0);
      end else begin
        m_pc  <= m_pc + 32'd4;
        m_mis <= 1'b0;
      end
      if (br_type >= 4'd1 && br_type <= 4'd6) begin
        m_brc <= m_brc + 32'd1;
        if (f_taken(br_type, {zero, gez, gz, lez, lz})) m_tkc <= m_tkc + 32'd1;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_pc_f", pc_f, m_pc);
      check("model_jr_misalign", 32'(jr_misalign), 32'(m_mis));
      check("model_taken", 32'(taken), 32'(f_taken(br_type, {zero, gez, gz, lez, lz})));
      check("model_link_pc", link_pc, pc_d + 32'd8);
`ifdef BRANCH_STATS_EN
      check("model_br_count", br_count, m_brc);
      check("model_taken_count", taken_count, m_tkc);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] bt, input logic [4:0] fl, input logic [31:0] pcd,
                       input logic [15:0] im, input logic [25:0] ix, input logic [31:0] rs);
    br_type = bt;
    {zero, gez, gz, lez, lz} = fl;
    pc_d   = pcd;
    imm16  = im;
    idx26  = ix;
    rs_val = rs;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset mid-cycle, visible without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("reset_pc_f", pc_f, 32'h0000_3000);
    check("reset_jr_misalign", 32'(jr_misalign), 32'd0);
    #9 reset = 1'b0;  // t=12, between edges
    chk_en = 1'b1;
    check("release_pc_f", pc_f, 32'h0000_3000);
    step();
    check("seq_pc_1", pc_f, 32'h0000_3004);
    step();
    check("seq_pc_2", pc_f, 32'h0000_3008);

    // BEQ taken backward: 0x3014 - 16.
    drive(BrBeq, 5'b10000, 32'h3010, 16'hFFFC, 26'd0, 32'd0);
    check("beq_taken", 32'(taken), 32'd1);
    step();
    check("beq_target", pc_f, 32'h0000_3004);
    // Same branch not taken.
    drive(BrBeq, 5'b00000, 32'h3010, 16'hFFFC, 26'd0, 32'd0);
    check("beq_not_taken", 32'(taken), 32'd0);
    step();
    check("beq_fallthru", pc_f, 32'h0000_3008);

    // Taken BGTZ held off by a 3-cycle stall: 0x300C + 0x40.
    drive(BrBgtz, 5'b01100, 32'h3008, 16'h0010, 26'd0, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", pc_f, 32'h0000_3008);
    end
    check("stall_taken_driven", 32'(taken), 32'd1);
    stall = 1'b0;
    step();
    check("bgtz_target", pc_f, 32'h0000_304C);

    // JAL
    drive(BrJal, 5'b00000, 32'h3020, 16'd0, 26'h0000C10, 32'd0);
    check("jal_link", link_pc, 32'h0000_3028);
    step();
    check("jal_target", pc_f, 32'h0000_3040);

    // JR misaligned, then cleared by NONE.
    drive(BrJr, 5'b00000, 32'h3040, 16'd0, 26'd0, 32'h3042);
    step();
    check("jr_pc", pc_f, 32'h0000_3042);
    check("jr_misalign_set", 32'(jr_misalign), 32'd1);
    drive(BrNone, 5'b00000, 32'h3044, 16'd0, 26'd0, 32'h3042);
    step();
    check("none_pc", pc_f, 32'h0000_3046);
    check("jr_misalign_clr", 32'(jr_misalign), 32'd0);

    // JALR aligned.
    drive(BrJalr, 5'b00000, 32'h3100, 16'd0, 26'd0, 32'h4000);
    check("jalr_link", link_pc, 32'h0000_3108);
    step();
    check("jalr_pc", pc_f, 32'h0000_4000);
    check("jalr_aligned", 32'(jr_misalign), 32'd0);

    // Unused code with all flags set acts as NONE.
    drive(4'd12, 5'b11111, 32'h4000, 16'h0100, 26'h1, 32'h3);
    check("undef_not_taken", 32'(taken), 32'd0);
    step();
    check("undef_pc", pc_f, 32'h0000_4004);

    // BLTZ not taken with odd rs: not a register jump, no flag.
    drive(BrBltz, 5'b01000, 32'h4004, 16'h0004, 26'd0, 32'h3);
    step();
    check("bltz_pc", pc_f, 32'h0000_4008);
    check("bltz_no_misalign", 32'(jr_misalign), 32'd0);

    // J to the top of the address space, then wrap to 0.
    drive(BrJ, 5'b00000, 32'hF000_0000, 16'd0, 26'h3FF_FFFF, 32'd0);
    step();
    check("j_top", pc_f, 32'hFFFF_FFFC);
    drive(BrNone, 5'b00000, 32'd0, 16'd0, 26'd0, 32'd0);
    step();
    check("pc_wrap", pc_f, 32'h0000_0000);

    // Mid-operation reset over a stalled taken BNE with the flag set.
    drive(BrJr, 5'b00000, 32'h0, 16'd0, 26'd0, 32'h3001);
    step();
    check("jr2_misalign", 32'(jr_misalign), 32'd1);
    stall = 1'b1;
    drive(BrBne, 5'b00000, 32'h3001, 16'h0040, 26'd0, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("midreset_pc", pc_f, 32'h0000_3000);
    check("midreset_misalign", 32'(jr_misalign), 32'd0);
    #3 reset = 1'b0;
    step();
    check("post_reset_stall", pc_f, 32'h0000_3000);
    stall = 1'b0;

    // Stats: 3 BNE (2 taken) and 1 J.
    drive(BrBne, 5'b00000, 32'h3000, 16'h0000, 26'd0, 32'd0);
    step();
    check("bne1_pc", pc_f, 32'h0000_3004);
    drive(BrBne, 5'b10000, 32'h3004, 16'h0000, 26'd0, 32'd0);
    step();
    check("bne2_pc", pc_f, 32'h0000_3008);
    drive(BrBne, 5'b00000, 32'h3008, 16'h0001, 26'd0, 32'd0);
    step();
    check("bne3_pc", pc_f, 32'h0000_3010);
    drive(BrJ, 5'b00000, 32'h3010, 16'd0, 26'h0000C00, 32'd0);
    step();
    check("j_pc", pc_f, 32'h0000_3000);
`ifdef BRANCH_STATS_EN
    check("stats_br_count", br_count, 32'd3);
    check("stats_taken_count", taken_count, 32'd2);
`endif
    drive(BrNone, 5'b00000, 32'd0, 16'd0, 26'd0, 32'd0);
    step();
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Fetch-side consumer of the D-stage compare flags (zero/gez/gz/lez/lz): resolves branch/jump type, computes the target, and owns the F-stage PC register.
- MIPS with one architectural delay slot: a taken control transfer resolved in D redirects the fetch after the one already in F.
- Sits between the D-stage comparator/decoder and instruction memory; also drives the link value for jal/jalr.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- PC_WIDTH, 32, width of every PC/address port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall from the hazard unit; freezes the PC.
- br_type  in  4  D-stage control-transfer code (package enum).
- zero  in  1  A==B flag from the D-stage comparator.
- gez  in  1  signed A>=0.
- gz  in  1  signed A>0.
- lez  in  1  signed A<=0.
- lz  in  1  signed A<0.
- pc_d  in  32  PC of the instruction in D.
- imm16  in  16  branch offset field.
- idx26  in  26  j/jal index field.
- rs_val  in  32  forwarded rs value for jr/jalr.
- pc_f  out  32  current fetch address.
- taken  out  1  D-stage transfer taken this cycle (combinational).
- link_pc  out  32  pc_d+8, written for jal/jalr.
- jr_misalign  out  1  registered; set when a taken jr/jalr target has bits[1:0]!=0.

Behaviour:
- Reset (async, active-high): pc_f=RESET_PC; jr_misalign=0. taken and link_pc are combinational on inputs.
- br_type codes: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6, J=7, JAL=8, JR=9, JALR=10. Codes 11-15 act as NONE.
- taken: BEQ=zero; BNE=!zero; BLEZ=lez; BGTZ=gz; BLTZ=lz; BGEZ=gez; J/JAL/JR/JALR=1; NONE=0.
- Targets, 32-bit wrap-around arithmetic, no overflow flag:
  - Branch target = pc_d+4+(sext(imm16)<<2).
  - J/JAL target = {pc_d+4 [31:28], idx26, 2'b00}.
  - JR/JALR target = rs_val, used unmodified.
- Next-PC selection:
  - stall=1: pc_f holds and jr_misalign holds. taken is still driven, but no state change.
  - stall=0, taken=1: pc_f <= target.
  - stall=0, taken=0: pc_f <= pc_f+4.
- Latency: one cycle. The taken branch is in D while the delay slot is in F. The next cycle's pc_f is the target.
- stall with taken branch: no buffering. D holds, so the branch re-resolves the next cycle with forwarded flags; the redirect occurs on the first unstalled edge.
- jr_misalign: on an unstalled edge, set to 1 if the transfer is taken, br_type is JR/JALR and rs_val[1:0]!=0; otherwise cleared. The PC is still loaded with the misaligned value.
- pc_f wraps from 32'hFFFF_FFFC to 0 with no error.
- Reset asserted mid-operation overrides stall and any pending redirect immediately, without waiting for a clock edge.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - Adds outputs br_count[31:0] and taken_count[31:0], both reset to 0.
  - On each unstalled edge with br_type in BEQ..BGEZ, br_count increments.
  - On that same edge, taken_count also increments if taken=1.
  - Both counters wrap modulo 2^32. Jumps are not counted.
- When undefined: the ports and counters are absent, and the functional behaviour is unchanged.

Decomposition:
- Shared package branch_pkg holds: br_type enum (4-bit), RESET_PC default, and the PC_INC=4 constant. The decoder and the bench reuse it.
- One natural sub-module, branch_target_gen: purely combinational taken and target selection from br_type, flags, pc_d, imm16, idx26 and rs_val. The top module keeps the PC register, the misalign register and the optional counters.

Test Plan:
- Reset and sequential fetch: assert reset mid-cycle, then release with stall=0 and NONE -> pc_f=0x3000 immediately, then 0x3004, then 0x3008.
- BEQ taken backward: pc_d=0x3010, imm16=16'hFFFC, zero=1 -> taken=1 and the next pc_f=0x3004. The same case with zero=0 -> pc_f+4.
- Stall over a taken BGTZ: gz=1 with stall=1 for 3 cycles -> pc_f unchanged for 3 cycles, then loads the target on the first unstalled edge.
- JAL: pc_d=0x3020, idx26=26'h0000C10 -> target=0x0000_3040 and link_pc=0x3028.
- JR misaligned: rs_val=0x3042 -> pc_f=0x3042 and jr_misalign=1 the next cycle. The following NONE cycle clears jr_misalign to 0.
- BRANCH_STATS_EN: issue 3 BNE (2 taken) plus 1 J -> br_count=3 and taken_count=2.
